snake_frame_scheduler: RTL and testbench

- Owns the snake position buffer and sequences its delivery to the game graphic renderer once per video frame.
- At the start of vertical blanking it:
  - applies at most one pending move/grow command from the game FSM,
  - checks for self-collision,
  - streams head and body coordinates one segment per cycle on snake_body_x/y under en_snake_body.
- The renderer therefore only ever sees a stable snake during active video.

---
 rtl/snake_pkg.sv | 39 +++
 rtl/snake_next_head.sv | 54 +++++
 rtl/snake_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_snake_frame_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, codes and helpers for the snake frame scheduler
package snake_pkg;

    localparam int PIXEL_DISPLAY_BIT = 9;
    localparam int SNAKE_LENGTH_BIT  = 4;
    localparam int SNAKE_LENGTH_MAX  = 16;
    localparam int GRID_W            = 124;
    localparam int GRID_H            = 81;
    localparam int V_ACTIVE          = 480;
    localparam int H_TRIGGER         = 799;

    localparam int RESET_HEAD_X      = 62;
    localparam int RESET_HEAD_Y      = 40;
    localparam int INIT_LENGTH       = 3;

    // Longest snake the length port can report; growth saturates here.
    localparam int LEN_CAP = (SNAKE_LENGTH_MAX < (1 << SNAKE_LENGTH_BIT)) ?
                             SNAKE_LENGTH_MAX : (1 << SNAKE_LENGTH_BIT) - 1;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        HEAD  = 2'b00,
        BODY  = 2'b01,
        TAIL  = 2'b10,
        FRUIT = 2'b11
    } figure_t;

    // Opposite direction: flipping the upper code bit swaps up/down and right/left.
    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// rtl/snake_next_head.sv - combinational next-head position with wrap and out-of-grid flag
module snake_next_head
    import snake_pkg::*;
(
    input  logic [6:0] i_head_x,
    input  logic [6:0] i_head_y,
    input  logic [1:0] i_dir,
    output logic [6:0] o_head_x,
    output logic [6:0] o_head_y,
    output logic       o_oob
);

    // One block step in the requested direction, wrapping at the playfield edges.
    always_comb begin
        o_head_x = i_head_x;
        o_head_y = i_head_y;
        o_oob    = 1'b0;
        case (i_dir)
            DIR_UP: begin
                if (i_head_y == 7'd0) begin
                    o_head_y = 7'(GRID_H - 1);
                    o_oob    = 1'b1;
                end else begin
                    o_head_y = i_head_y - 7'd1;
                end
            end
            DIR_RIGHT: begin
                if (i_head_x == 7'(GRID_W - 1)) begin
                    o_head_x = 7'd0;
                    o_oob    = 1'b1;
                end else begin
                    o_head_x = i_head_x + 7'd1;
                end
            end
            DIR_DOWN: begin
                if (i_head_y == 7'(GRID_H - 1)) begin
                    o_head_y = 7'd0;
                    o_oob    = 1'b1;
                end else begin
                    o_head_y = i_head_y + 7'd1;
                end
            end
            default: begin
                if (i_head_x == 7'd0) begin
                    o_head_x = 7'(GRID_W - 1);
                    o_oob    = 1'b1;
                end else begin
                    o_head_x = i_head_x - 7'd1;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_frame_scheduler.sv
// rtl/snake_frame_scheduler.sv - snake buffer update and per-frame segment streaming (option: SNAKE_WALL_KILL_EN)
module snake_frame_scheduler
    import snake_pkg::*;
(
    input  logic                         clock_25,
    input  logic                         reset,
    input  logic [PIXEL_DISPLAY_BIT:0]   X,
    input  logic [PIXEL_DISPLAY_BIT:0]   Y,
    input  logic                         move_req,
    input  logic                         grow_req,
    input  logic [1:0]                   dir_req,
    output logic [6:0]                   snake_head_x,
    output logic [6:0]                   snake_head_y,
    output logic [6:0]                   snake_body_x,
    output logic [6:0]                   snake_body_y,
    output logic                         en_snake_body,
    output logic [SNAKE_LENGTH_BIT-1:0]  snake_length,
    output logic                         frame_tick,
    output logic                         move_ack,
    output logic                         self_hit,
    output logic                         wall_hit
);

`ifdef SNAKE_WALL_KILL_EN
    localparam bit WALL_KILL_EN = 1'b1;
`else
    localparam bit WALL_KILL_EN = 1'b0;
`endif

    localparam logic [SNAKE_LENGTH_BIT-1:0] ONE = SNAKE_LENGTH_BIT'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT,
        ST_STREAM,
        ST_GAP
    } state_t;

    state_t                       r_state, w_state_nxt;
    logic [SNAKE_LENGTH_BIT-1:0]  r_idx, w_idx_nxt;

    logic [6:0]                   r_seg_x [SNAKE_LENGTH_MAX];
    logic [6:0]                   r_seg_y [SNAKE_LENGTH_MAX];
    logic [SNAKE_LENGTH_BIT-1:0]  r_length;
    logic [1:0]                   r_dir;

    logic                         r_pending;
    logic                         r_pend_grow;
    logic [1:0]                   r_pend_dir;

    logic [6:0]                   r_new_x, r_new_y;
    logic                         r_new_oob;
    logic [1:0]                   r_new_dir;
    logic                         r_grow;

    logic                         w_trigger;
    logic                         w_pend_eff;
    logic                         w_cap_grow;
    logic [1:0]                   w_cap_dir;
    logic [1:0]                   w_eff_dir;
    logic [6:0]                   w_next_x, w_next_y;
    logic                         w_next_oob;
    logic                         w_hit;
    logic [SNAKE_LENGTH_BIT-1:0]  w_check_last;
    logic                         w_take, w_shift, w_ack, w_self, w_wall, w_tick;

    assign w_trigger  = (X == (PIXEL_DISPLAY_BIT+1)'(H_TRIGGER)) &&
                        (Y == (PIXEL_DISPLAY_BIT+1)'(V_ACTIVE - 1));
    // A request landing on the trigger cycle is folded into this frame.
    assign w_pend_eff = r_pending | move_req;
    assign w_cap_grow = move_req ? grow_req : r_pend_grow;
    assign w_cap_dir  = move_req ? dir_req  : r_pend_dir;
    assign w_eff_dir  = (w_cap_dir == dir_reverse(r_dir)) ? r_dir : w_cap_dir;

    snake_next_head u_next_head (
        .i_head_x (r_seg_x[0]),
        .i_head_y (r_seg_y[0]),
        .i_dir    (w_eff_dir),
        .o_head_x (w_next_x),
        .o_head_y (w_next_y),
        .o_oob    (w_next_oob)
    );

    assign w_hit        = (r_seg_x[r_idx] == r_new_x) && (r_seg_y[r_idx] == r_new_y);
    // The tail vacates its block on a plain move, so it only blocks when growing.
    assign w_check_last = r_grow ? (r_length - ONE) : (r_length - SNAKE_LENGTH_BIT'(2));

    // FSM state and segment index register.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state, index walk and pulse outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tick      = 1'b0;
        w_take      = 1'b0;
        w_shift     = 1'b0;
        w_ack       = 1'b0;
        w_self      = 1'b0;
        w_wall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_tick = 1'b1;
                    if (w_pend_eff) begin
                        w_take      = 1'b1;
                        w_idx_nxt   = ONE;
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_STREAM;
                    end
                end
            end
            ST_CHECK: begin
                if (WALL_KILL_EN && r_new_oob) begin
                    w_wall      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_STREAM;
                end else if (w_hit) begin
                    w_self      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_STREAM;
                end else if (r_idx == w_check_last) begin
                    w_idx_nxt   = r_grow ? r_length : (r_length - ONE);
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_idx_nxt   = r_idx + ONE;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_idx == ONE) begin
                    w_ack       = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_idx_nxt   = r_idx - ONE;
                end
            end
            ST_STREAM: begin
                if (r_idx == (r_length - ONE)) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_idx_nxt   = r_idx + ONE;
                end
            end
            ST_GAP: begin
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch: last request wins; taking it at the trigger empties the slot.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_pending   <= 1'b0;
            r_pend_grow <= 1'b0;
            r_pend_dir  <= DIR_RIGHT;
        end else if (w_take) begin
            r_pending   <= 1'b0;
        end else if (move_req) begin
            r_pending   <= 1'b1;
            r_pend_grow <= grow_req;
            r_pend_dir  <= dir_req;
        end
    end

    // Freeze the step being applied so late requests cannot disturb CHECK/SHIFT.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_new_x   <= '0;
            r_new_y   <= '0;
            r_new_oob <= 1'b0;
            r_new_dir <= DIR_RIGHT;
            r_grow    <= 1'b0;
        end else if (w_take) begin
            r_new_x   <= w_next_x;
            r_new_y   <= w_next_y;
            r_new_oob <= w_next_oob;
            r_new_dir <= w_eff_dir;
            r_grow    <= w_cap_grow && (r_length < SNAKE_LENGTH_BIT'(LEN_CAP));
        end
    end

    // Segment buffer: shift one entry per SHIFT cycle, head written on the last one.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
                r_seg_x[i] <= (i < INIT_LENGTH) ? 7'(RESET_HEAD_X - i) : 7'd0;
                r_seg_y[i] <= (i < INIT_LENGTH) ? 7'(RESET_HEAD_Y) : 7'd0;
            end
        end else if (w_shift) begin
            r_seg_x[r_idx] <= r_seg_x[r_idx - ONE];
            r_seg_y[r_idx] <= r_seg_y[r_idx - ONE];
            if (r_idx == ONE) begin
                r_seg_x[0] <= r_new_x;
                r_seg_y[0] <= r_new_y;
            end
        end
    end

    // Length and heading commit together with the new head.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_length <= SNAKE_LENGTH_BIT'(INIT_LENGTH);
            r_dir    <= DIR_RIGHT;
        end else if (w_ack) begin
            r_dir <= r_new_dir;
            if (r_grow) begin
                r_length <= r_length + ONE;
            end
        end
    end

    assign en_snake_body = (r_state == ST_STREAM);
    assign snake_body_x  = en_snake_body ? r_seg_x[r_idx] : 7'd0;
    assign snake_body_y  = en_snake_body ? r_seg_y[r_idx] : 7'd0;
    assign snake_head_x  = r_seg_x[0];
    assign snake_head_y  = r_seg_y[0];
    assign snake_length  = r_length;
    assign frame_tick    = w_tick;
    assign move_ack      = w_ack;
    assign self_hit      = w_self;
    assign wall_hit      = w_wall;

endmodule

// File: tb/tb_snake_frame_scheduler.sv
// tb/tb_snake_frame_scheduler.sv - directed self-checking bench for snake_frame_scheduler
module tb_snake_frame_scheduler;
    import snake_pkg::*;

    logic                         clock_25 = 1'b0;
    logic                         reset    = 1'b0;
    logic [PIXEL_DISPLAY_BIT:0]   X        = '0;
    logic [PIXEL_DISPLAY_BIT:0]   Y        = '0;
    logic                         move_req = 1'b0;
    logic                         grow_req = 1'b0;
    logic [1:0]                   dir_req  = 2'b01;
    logic [6:0]                   snake_head_x, snake_head_y;
    logic [6:0]                   snake_body_x, snake_body_y;
    logic                         en_snake_body;
    logic [SNAKE_LENGTH_BIT-1:0]  snake_length;
    logic                         frame_tick, move_ack, self_hit, wall_hit;

    int errors = 0;
    int checks = 0;
    int ex [16];
    int ey [16];
    int n_ack, n_self, n_wall;

    snake_frame_scheduler dut (
        .clock_25      (clock_25),
        .reset         (reset),
        .X             (X),
        .Y             (Y),
        .move_req      (move_req),
        .grow_req      (grow_req),
        .dir_req       (dir_req),
        .snake_head_x  (snake_head_x),
        .snake_head_y  (snake_head_y),
        .snake_body_x  (snake_body_x),
        .snake_body_y  (snake_body_y),
        .en_snake_body (en_snake_body),
        .snake_length  (snake_length),
        .frame_tick    (frame_tick),
        .move_ack      (move_ack),
        .self_hit      (self_hit),
        .wall_hit      (wall_hit)
    );

    always #5 clock_25 = ~clock_25;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        #1;
        n_ack  += int'(move_ack);
        n_self += int'(self_hit);
        n_wall += int'(wall_hit);
    endtask

    task automatic set_line(input int hx, input int y, input int n);
        for (int k = 0; k < n; k++) begin
            ex[k] = hx - k;
            ey[k] = y;
        end
    endtask

    task automatic req(input logic [1:0] d, input logic g);
        move_req = 1'b1;
        dir_req  = d;
        grow_req = g;
        tick();
        move_req = 1'b0;
        grow_req = 1'b0;
    endtask

    // Fire the frame trigger, wait (bounded) for the stream and optionally check it.
    task automatic frame(input bit do_chk, input int n);
        int got;
        n_ack  = 0;
        n_self = 0;
        n_wall = 0;
        X = 10'd799;
        Y = 10'd479;
        #1;
        if (do_chk) chk("frame_tick", frame_tick, 1);
        tick();
        X = '0;
        Y = '0;
        got = 0;
        for (int c = 0; c < 60 && got == 0; c++) begin
            if (en_snake_body) got = 1;
            else tick();
        end
        chk("stream_start", got, 1);
        for (int k = 0; k < n; k++) begin
            if (do_chk) begin
                chk($sformatf("seg%0d_en", k), en_snake_body, 1);
                chk($sformatf("seg%0d_x", k), snake_body_x, ex[k]);
                chk($sformatf("seg%0d_y", k), snake_body_y, ey[k]);
            end
            tick();
        end
        if (do_chk) chk("stream_end", en_snake_body, 0);
        tick();
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_head_x", snake_head_x, 62);
        chk("rst_head_y", snake_head_y, 40);
        chk("rst_length", snake_length, 3);
        chk("rst_en", en_snake_body, 0);
        chk("rst_body_x", snake_body_x, 0);
        chk("rst_body_y", snake_body_y, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_ack", move_ack, 0);
        chk("rst_self", self_hit, 0);
        chk("rst_wall", wall_hit, 0);
        reset = 1'b1;
        tick();

        // Idle frame streams the reset snake
        set_line(62, 40, 3);
        frame(1, 3);
        chk("idle_ack", n_ack, 0);

        // Plain move right
        req(2'b01, 1'b0);
        set_line(63, 40, 3);
        frame(1, 3);
        chk("move_ack", n_ack, 1);
        chk("move_len", snake_length, 3);
        chk("move_head_x", snake_head_x, 63);

        // Four requests, last one (right, grow) wins
        req(2'b10, 1'b1);
        req(2'b10, 1'b1);
        req(2'b10, 1'b1);
        req(2'b01, 1'b1);
        set_line(64, 40, 4);
        frame(1, 4);
        chk("grow_ack", n_ack, 1);
        chk("grow_len", snake_length, 4);

        // Reverse direction is ignored
        req(2'b11, 1'b0);
        set_line(65, 40, 4);
        frame(1, 4);
        chk("rev_head_x", snake_head_x, 65);
        chk("rev_len", snake_length, 4);

        // Walk to the right edge
        for (int i = 0; i < 58; i++) begin
            req(2'b01, 1'b0);
            frame(0, 4);
        end
        chk("edge_head_x", snake_head_x, 123);

        // Step off the right edge
        req(2'b01, 1'b0);
`ifdef SNAKE_WALL_KILL_EN
        set_line(123, 40, 4);
        frame(1, 4);
        chk("wall_pulse", n_wall, 1);
        chk("wall_ack", n_ack, 0);
        chk("wall_head_x", snake_head_x, 123);
`else
        ex[0] = 0;   ey[0] = 40;
        ex[1] = 123; ey[1] = 40;
        ex[2] = 122; ey[2] = 40;
        ex[3] = 121; ey[3] = 40;
        frame(1, 4);
        chk("wrap_pulse", n_wall, 0);
        chk("wrap_ack", n_ack, 1);
        chk("wrap_head_x", snake_head_x, 0);
`endif

        // Build a length-5 U so the next up step lands on seg3
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        req(2'b01, 1'b1);
        frame(0, 4);
        req(2'b01, 1'b1);
        frame(0, 5);
        req(2'b10, 1'b0);
        frame(0, 5);
        req(2'b11, 1'b0);
        ex[0] = 63; ey[0] = 41;
        ex[1] = 64; ey[1] = 41;
        ex[2] = 64; ey[2] = 40;
        ex[3] = 63; ey[3] = 40;
        ex[4] = 62; ey[4] = 40;
        frame(1, 5);
        chk("u_len", snake_length, 5);
        req(2'b00, 1'b0);
        frame(1, 5);
        chk("self_pulse", n_self, 1);
        chk("self_ack", n_ack, 0);
        chk("self_head_y", snake_head_y, 41);
        frame(1, 5);
        chk("self_cleared_self", n_self, 0);
        chk("self_cleared_ack", n_ack, 0);

        // Reset in the middle of a stream
        X = 10'd799;
        Y = 10'd479;
        tick();
        X = '0;
        Y = '0;
        chk("mid_en_before", en_snake_body, 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mid_en_after", en_snake_body, 0);
        chk("mid_body_x", snake_body_x, 0);
        chk("mid_head_x", snake_head_x, 62);
        chk("mid_head_y", snake_head_y, 40);
        chk("mid_len", snake_length, 3);
        tick();
        reset = 1'b1;
        tick();
        set_line(62, 40, 3);
        frame(1, 3);
        chk("post_rst_ack", n_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
